// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types for the two-master APB arbiter.
//   state_t     : transfer sequencer states (IDLE -> SETUP -> ACCESS -> RESP)
//   bus_req_t   : one master's latched transfer fields (we, addr, wdata, be)
//   STRB_W      : byte-strobe width for the default data width
//   cnt_width() : width of the wait-state counter for a given timeout
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int STRB_W     = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [STRB_W-1:0]     be;
    } bus_req_t;

    // clog2(timeout+1), never narrower than one bit (timeout 0 still needs a
    // legal vector even though the counter is then never compared).
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter. The grant is combinational from the two
// requests and the last-grant register; the register only moves when the
// owner of the shared resource signals that it has accepted a grant.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-low reset (last grant -> 1, so
//                  requester 0 wins the first tie)
//   i_req0/1  in   requests
//   i_update  in   accept the current grant and record it as last grant
//   o_valid   out  at least one request present
//   o_grant   out  index of the winning requester
// -----------------------------------------------------------------------------
module rr_arbiter_2 (
    input  logic clk,
    input  logic reset,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_update,
    output logic o_valid,
    output logic o_grant
);

    logic r_last_grant;

    always_comb begin
        o_valid = i_req0 | i_req1;
        // On a tie the requester that did not win last time goes first.
        if (i_req0 && i_req1) begin
            o_grant = ~r_last_grant;
        end else begin
            o_grant = i_req1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (i_update && o_valid) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// apb_bus_arbiter
// Shares one APB port between master 0 (CPU data bus) and master 1 (boot
// loader / DMA). Requests are arbitrated round-robin in IDLE, the winner's
// fields are latched, and the transfer is sequenced SETUP -> ACCESS -> RESP.
// The granted master gets a registered one-cycle ready pulse with rdata/err.
// A wait-state counter forces an error completion after TIMEOUT ACCESS
// cycles without p_ready (TIMEOUT = 0 disables it).
// Ports:
//   clk, reset                     clock, async active-low reset
//   mX_req/we/addr/wdata/be        master X request (held until mX_ready)
//   mX_rdata/ready/err             master X response
//   p_addr/write/sel/enable/       APB request side (p_strb zero on reads)
//   p_wdata/strb
//   p_rdata/ready/slverr           APB response side
// The latched request uses bus_pkg::bus_req_t, so ADDR_W/DATA_W must stay at
// the package widths.
// -----------------------------------------------------------------------------
module apb_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                m1_err,
    output logic [ADDR_W-1:0]   p_addr,
    output logic                p_write,
    output logic                p_sel,
    output logic                p_enable,
    output logic [DATA_W-1:0]   p_wdata,
    output logic [DATA_W/8-1:0] p_strb,
    input  logic [DATA_W-1:0]   p_rdata,
    input  logic                p_ready,
    input  logic                p_slverr
);

    localparam int              CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W:0]  TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

    state_t              r_state;
    bus_req_t            r_req;
    logic                r_gnt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_p_sel;
    logic                r_p_enable;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_m0_ready;
    logic                r_m1_ready;
    logic                r_m0_err;
    logic                r_m1_err;

    logic                w_valid;
    logic                w_grant;
    logic                w_update;
    bus_req_t            w_win;
    logic [CNT_W:0]      w_cnt_inc;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_rsp_rdata;
    logic                w_rsp_err;

    // Requests are only looked at in IDLE; that is also when a grant is taken.
    assign w_update = (r_state == IDLE);

    rr_arbiter_2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req0   (m0_req),
        .i_req1   (m1_req),
        .i_update (w_update),
        .o_valid  (w_valid),
        .o_grant  (w_grant)
    );

    // Winner's fields; strobes are masked here so reads carry p_strb = 0.
    always_comb begin
        w_win = '0;
        if (w_grant) begin
            w_win.we    = m1_we;
            w_win.addr  = m1_addr;
            w_win.wdata = m1_wdata;
            w_win.be    = m1_we ? m1_be : '0;
        end else begin
            w_win.we    = m0_we;
            w_win.addr  = m0_addr;
            w_win.wdata = m0_wdata;
            w_win.be    = m0_we ? m0_be : '0;
        end
    end

    // The current ACCESS cycle is the (r_cnt+1)-th; time out on the
    // TIMEOUT-th one if the slave still has not answered.
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc >= TO_LIMIT);

    // Writes return zero data; a timeout returns zero data with err set.
    always_comb begin
        w_rsp_rdata = '0;
        w_rsp_err   = 1'b1;
        if (p_ready) begin
            w_rsp_err = p_slverr;
            if (!r_req.we) begin
                w_rsp_rdata = p_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_gnt      <= 1'b0;
            r_cnt      <= '0;
            r_p_sel    <= 1'b0;
            r_p_enable <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m1_err   <= 1'b0;
        end else begin
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m1_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_req   <= w_win;
                        r_gnt   <= w_grant;
                        r_cnt   <= '0;
                        r_p_sel <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_p_enable <= 1'b1;
                    r_state    <= ACCESS;
                end
                ACCESS: begin
                    if (!(&r_cnt)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (p_ready || w_timeout) begin
                        r_p_sel    <= 1'b0;
                        r_p_enable <= 1'b0;
                        r_state    <= RESP;
                        if (r_gnt) begin
                            r_m1_ready <= 1'b1;
                            r_m1_err   <= w_rsp_err;
                            r_m1_rdata <= w_rsp_rdata;
                        end else begin
                            r_m0_ready <= 1'b1;
                            r_m0_err   <= w_rsp_err;
                            r_m0_rdata <= w_rsp_rdata;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign p_addr   = r_req.addr;
    assign p_write  = r_req.we;
    assign p_wdata  = r_req.wdata;
    assign p_strb   = r_req.be;
    assign p_sel    = r_p_sel;
    assign p_enable = r_p_enable;

    assign m0_rdata = r_m0_rdata;
    assign m0_ready = r_m0_ready;
    assign m0_err   = r_m0_err;
    assign m1_rdata = r_m1_rdata;
    assign m1_ready = r_m1_ready;
    assign m1_err   = r_m1_err;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_bus_arbiter
// Self-checking bench for apb_bus_arbiter (TIMEOUT = 4). A behavioural APB
// slave answers each transfer; in "auto" mode its wait states, error and read
// data are derived from the address so random traffic has a known answer.
// Expected completions are computed from the arbitration/latency rules.
// -----------------------------------------------------------------------------
module tb_apb_bus_arbiter;

    localparam int TO = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_be = '0;
    logic [31:0] m0_rdata;
    logic        m0_ready, m0_err;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_be = '0;
    logic [31:0] m1_rdata;
    logic        m1_ready, m1_err;
    logic [31:0] p_addr, p_wdata;
    logic        p_write, p_sel, p_enable;
    logic [3:0]  p_strb;
    logic [31:0] p_rdata = '0;
    logic        p_ready = 1'b0, p_slverr = 1'b0;

    always #5 clk = ~clk;

    apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .p_addr(p_addr), .p_write(p_write), .p_sel(p_sel), .p_enable(p_enable),
        .p_wdata(p_wdata), .p_strb(p_strb), .p_rdata(p_rdata), .p_ready(p_ready),
        .p_slverr(p_slverr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural APB slave ----------------
    int          slv_wait = 0;
    bit          slv_never = 0, slv_err_en = 0, slv_auto = 0;
    logic [31:0] slv_rdata = '0;
    int          acc = 0;
    int          sw;
    logic        se;
    logic [31:0] sd;

    always @(negedge clk) begin
        if (p_sel && p_enable) begin
            if (slv_auto) begin
                sw = int'(p_addr[3:2]);
                se = p_addr[4];
                sd = ~p_addr;
            end else begin
                sw = slv_wait;
                se = slv_err_en;
                sd = slv_rdata;
            end
            p_ready  = !slv_never && (acc == sw);
            p_rdata  = p_ready ? sd : $urandom;
            p_slverr = p_ready ? se : 1'($urandom);
            acc++;
        end else begin
            p_ready  = 1'b0;
            p_slverr = 1'b0;
            p_rdata  = $urandom;
            acc      = 0;
        end
    end

    // ---------------- observation and reference model ----------------
    typedef struct { int m; int c; logic [31:0] rd; logic er; } ev_t;
    typedef struct { logic [31:0] a; logic w; logic [31:0] wd; logic [3:0] s; } ph_t;

    ev_t evq[$];
    ev_t exq[$];
    ph_t phq[$];
    ph_t exph[$];
    int  both_rdy = 0;
    int  model_last = 1;
    logic        mdl_we[2];
    logic [31:0] mdl_addr[2];
    logic [31:0] mdl_wdata[2];
    logic [3:0]  mdl_be[2];

    task automatic set_master(input int m, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
        mdl_we[m] = we; mdl_addr[m] = a; mdl_wdata[m] = d; mdl_be[m] = be;
        if (m == 0) begin
            m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be; m1_req = 1'b1;
        end
    endtask

    // Watch ncyc cycles; log ready pulses and SETUP-phase bus values. A master
    // drops its request on its ready pulse unless told to keep holding it.
    task automatic monitor(input int ncyc, input bit hold0, input bit hold1);
        evq.delete(); phq.delete(); both_rdy = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (m0_ready && m1_ready) both_rdy++;
            if (p_sel && !p_enable) phq.push_back('{p_addr, p_write, p_wdata, p_strb});
            if (m0_ready) begin
                evq.push_back('{0, cyc, m0_rdata, m0_err});
                $display("[TB] xfer m0 cyc %0d rdata %h err %b", cyc, m0_rdata, m0_err);
                if (!hold0) m0_req = 1'b0;
            end
            if (m1_ready) begin
                evq.push_back('{1, cyc, m1_rdata, m1_err});
                $display("[TB] xfer m1 cyc %0d rdata %h err %b", cyc, m1_rdata, m1_err);
                if (!hold1) m1_req = 1'b0;
            end
        end
    endtask

    // Expected completions for requests raised in IDLE cycle n with the
    // address-driven slave: round-robin order, 3 cycles + wait states each,
    // the next transfer sampled in the IDLE cycle after the previous RESP.
    task automatic expect_auto(input int n, input bit r0, input bit r1);
        int order[$];
        int t;
        exq.delete(); exph.delete();
        t = n;
        if (r0 && r1) begin
            order.push_back(1 - model_last);
            order.push_back(model_last);
        end else if (r0) begin
            order.push_back(0);
        end else if (r1) begin
            order.push_back(1);
        end
        foreach (order[k]) begin
            int  m;
            ev_t e;
            ph_t p;
            m    = order[k];
            e.m  = m;
            e.c  = t + 3 + int'(mdl_addr[m][3:2]);
            e.rd = mdl_we[m] ? 32'h0 : ~mdl_addr[m];
            e.er = mdl_addr[m][4];
            exq.push_back(e);
            p.a  = mdl_addr[m];
            p.w  = mdl_we[m];
            p.wd = mdl_wdata[m];
            p.s  = mdl_we[m] ? mdl_be[m] : 4'h0;
            exph.push_back(p);
            t = e.c + 1;
            model_last = m;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({p_sel, p_enable, p_write} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: sel/en/wr=%b expected 000", {p_sel, p_enable, p_write});
        end
        n_tests++;
        if ({p_addr, p_wdata, p_strb} !== 68'h0) begin
            n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h strb=%h expected zeros", p_addr, p_wdata, p_strb);
        end
        n_tests++;
        if ({m0_ready, m0_err, m1_ready, m1_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rsp: rdy/err=%b expected 0000", {m0_ready, m0_err, m1_ready, m1_err});
        end
        n_tests++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: m0=%h m1=%h expected 0", m0_rdata, m1_rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        model_last = 1;
        @(posedge clk); #1;
        n_tests++;
        if (p_sel !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: p_sel=%b expected 0", p_sel);
        end
    endtask

    task automatic test_single_read();
        slv_auto = 0; slv_wait = 0; slv_never = 0; slv_err_en = 0; slv_rdata = 32'hCAFE_0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_master(0, 1'b0, 32'h1000_0004, $urandom, 4'hF);
        @(posedge clk); #1;
        n_tests++;
        if ({p_sel, p_enable, p_write, p_strb} !== 7'b1000000 || p_addr !== 32'h1000_0004) begin
            n_fail++; $display("FAIL rd_setup: sel/en/wr/strb=%b addr=%h expected 1000000 addr 10000004",
                               {p_sel, p_enable, p_write, p_strb}, p_addr);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({p_sel, p_enable} !== 2'b11 || m0_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_access: sel/en=%b ready=%b expected 11 0", {p_sel, p_enable}, m0_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'hCAFE_0001 || m0_err !== 1'b0 || m1_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_resp: ready=%b rdata=%h err=%b m1_ready=%b expected 1 cafe0001 0 0",
                               m0_ready, m0_rdata, m0_err, m1_ready);
        end
        $display("[TB] xfer m0 cyc %0d rdata %h err %b", cyc, m0_rdata, m0_err);
        m0_req = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (m0_ready !== 1'b0 || p_sel !== 1'b0 || m0_rdata !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL rd_after: ready=%b sel=%b rdata=%h expected 0 0 cafe0001", m0_ready, p_sel, m0_rdata);
        end
        model_last = 0;
    endtask

    task automatic test_write_wait();
        bit bad;
        slv_auto = 0; slv_wait = 3; slv_rdata = 32'h1357_9BDF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_master(1, 1'b1, 32'h2000_0000, 32'hA5A5_A5A5, 4'b0011);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bad = 0;
            if (k <= 5) begin
                if (p_sel !== 1'b1 || p_enable !== (k >= 2) || p_write !== 1'b1 || p_strb !== 4'b0011 ||
                    p_wdata !== 32'hA5A5_A5A5 || p_addr !== 32'h2000_0000) bad = 1;
            end
            if (m1_ready !== (k == 6) || m0_ready !== 1'b0) bad = 1;
            if (k == 6 && (m1_err !== 1'b0 || m1_rdata !== 32'h0)) bad = 1;
            n_tests++;
            if (bad) begin
                n_fail++; $display("FAIL wr_cycle%0d: sel=%b en=%b wr=%b strb=%b wdata=%h addr=%h m1_rdy=%b m1_err=%b m1_rd=%h m0_rdy=%b expected write 0011 a5a5a5a5 @20000000, m1_ready only at cycle 6",
                                   k, p_sel, p_enable, p_write, p_strb, p_wdata, p_addr, m1_ready, m1_err, m1_rdata, m0_ready);
            end
            if (k == 6) $display("[TB] xfer m1 cyc %0d rdata %h err %b", cyc, m1_rdata, m1_err);
        end
        m1_req = 1'b0;
        n_tests++;
        if (m0_rdata !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL wr_m0_hold: m0_rdata=%h expected cafe0001", m0_rdata);
        end
        model_last = 1;
    endtask

    task automatic test_contention();
        int n, f;
        slv_auto = 1; slv_never = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n = cyc;
        set_master(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
        set_master(1, 1'b0, 32'h4000_0040, 32'h0, 4'hF);
        monitor(16, 1'b1, 1'b1);
        m0_req = 1'b0; m1_req = 1'b0;
        f = 1 - model_last;
        n_tests++;
        if (evq.size() != 4 || both_rdy != 0) begin
            n_fail++; $display("FAIL cont_count: %0d completions, %0d overlaps, expected 4 and 0", evq.size(), both_rdy);
        end
        for (int k = 0; k < 4 && k < evq.size(); k++) begin
            int m;
            m = (k % 2 == 0) ? f : 1 - f;
            n_tests++;
            if (evq[k].m != m || evq[k].c != n + 3 + 4 * k || evq[k].rd !== ~mdl_addr[m] || evq[k].er !== 1'b0) begin
                n_fail++; $display("FAIL cont_ev%0d: m%0d cyc %0d rd=%h er=%b expected m%0d cyc %0d rd=%h er=0",
                                   k, evq[k].m, evq[k].c, evq[k].rd, evq[k].er, m, n + 3 + 4 * k, ~mdl_addr[m]);
            end
        end
        model_last = 1 - f;
    endtask

    task automatic test_timeout();
        int n;
        slv_auto = 0; slv_never = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n = cyc;
        set_master(0, 1'b0, 32'h5000_0000, 32'h0, 4'hF);
        monitor(8, 1'b0, 1'b0);
        n_tests++;
        if (evq.size() != 1) begin
            n_fail++; $display("FAIL to_count: %0d completions expected 1", evq.size());
        end else begin
            n_tests++;
            if (evq[0].m != 0 || evq[0].c != n + 2 + TO || evq[0].rd !== 32'h0 || evq[0].er !== 1'b1) begin
                n_fail++; $display("FAIL to_ev: m%0d cyc %0d rd=%h er=%b expected m0 cyc %0d rd=0 er=1",
                                   evq[0].m, evq[0].c, evq[0].rd, evq[0].er, n + 2 + TO);
            end
        end
        n_tests++;
        if (p_sel !== 1'b0 || p_enable !== 1'b0) begin
            n_fail++; $display("FAIL to_idle: sel=%b en=%b expected 0 0", p_sel, p_enable);
        end
        slv_never = 0;
        model_last = 0;
    endtask

    task automatic test_slverr();
        int n;
        slv_auto = 0; slv_wait = 0; slv_never = 0;
        for (int pass = 0; pass < 2; pass++) begin
            slv_err_en = (pass == 0);
            slv_rdata  = (pass == 0) ? 32'h1234_5678 : 32'h8765_4321;
            repeat (2) @(posedge clk);
            @(negedge clk);
            n = cyc;
            set_master(1, 1'b0, 32'h6000_0008, 32'h0, 4'hF);
            monitor(6, 1'b0, 1'b0);
            n_tests++;
            if (evq.size() != 1 || evq[0].m != 1 || evq[0].c != n + 3 || evq[0].rd !== slv_rdata ||
                evq[0].er !== (pass == 0)) begin
                n_fail++; $display("FAIL slverr_p%0d: %0d completions, first m%0d cyc %0d rd=%h er=%b expected m1 cyc %0d rd=%h er=%0d",
                                   pass, evq.size(), (evq.size() > 0) ? evq[0].m : -1, (evq.size() > 0) ? evq[0].c : -1,
                                   (evq.size() > 0) ? evq[0].rd : 32'hx, (evq.size() > 0) ? evq[0].er : 1'bx,
                                   n + 3, slv_rdata, (pass == 0));
            end
        end
        slv_err_en = 0;
        model_last = 1;
    endtask

    task automatic test_random();
        int n, pat;
        bit done[2];
        logic [31:0] last_rd[2];
        slv_auto = 1; slv_never = 0;
        done[0] = 0; done[1] = 0;
        for (int it = 0; it < 30; it++) begin
            @(posedge clk);
            @(negedge clk);
            n   = cyc;
            pat = $urandom_range(1, 3);
            if (pat[0]) set_master(0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            if (pat[1]) set_master(1, 1'($urandom), $urandom, $urandom, 4'($urandom));
            expect_auto(n, pat[0], pat[1]);
            monitor(18, 1'b0, 1'b0);
            n_tests++;
            if (evq.size() != exq.size() || phq.size() != exph.size() || both_rdy != 0) begin
                n_fail++; $display("FAIL rand%0d_count: %0d completions %0d setups %0d overlaps, expected %0d %0d 0",
                                   it, evq.size(), phq.size(), both_rdy, exq.size(), exph.size());
            end
            for (int k = 0; k < exq.size() && k < evq.size(); k++) begin
                n_tests++;
                if (evq[k].m != exq[k].m || evq[k].c != exq[k].c || evq[k].rd !== exq[k].rd || evq[k].er !== exq[k].er) begin
                    n_fail++; $display("FAIL rand%0d_ev%0d: m%0d cyc %0d rd=%h er=%b expected m%0d cyc %0d rd=%h er=%b",
                                       it, k, evq[k].m, evq[k].c, evq[k].rd, evq[k].er,
                                       exq[k].m, exq[k].c, exq[k].rd, exq[k].er);
                end
                done[exq[k].m]    = 1;
                last_rd[exq[k].m] = exq[k].rd;
            end
            for (int k = 0; k < exph.size() && k < phq.size(); k++) begin
                n_tests++;
                if (phq[k].a !== exph[k].a || phq[k].w !== exph[k].w || phq[k].s !== exph[k].s ||
                    (exph[k].w && phq[k].wd !== exph[k].wd)) begin
                    n_fail++; $display("FAIL rand%0d_bus%0d: addr=%h wr=%b strb=%b wdata=%h expected addr=%h wr=%b strb=%b wdata=%h",
                                       it, k, phq[k].a, phq[k].w, phq[k].s, phq[k].wd,
                                       exph[k].a, exph[k].w, exph[k].s, exph[k].wd);
                end
            end
            n_tests++;
            if ((done[0] && m0_rdata !== last_rd[0]) || (done[1] && m1_rdata !== last_rd[1])) begin
                n_fail++; $display("FAIL rand%0d_hold: m0_rdata=%h m1_rdata=%h expected %h %h",
                                   it, m0_rdata, m1_rdata, last_rd[0], last_rd[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        slv_auto = 0; slv_never = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_master(0, 1'b0, 32'h7000_0000, 32'h0, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if ({p_sel, p_enable} !== 2'b11) begin
            n_fail++; $display("FAIL ar_access: sel/en=%b expected 11", {p_sel, p_enable});
        end
        @(negedge clk);
        #2;
        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        n_tests++;
        if ({p_sel, p_enable} !== 2'b00) begin
            n_fail++; $display("FAIL ar_drop: sel/en=%b expected 00 right after reset", {p_sel, p_enable});
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                n_fail++; $display("FAIL ar_noready%0d: m0_ready=%b m1_ready=%b expected 0 0", k, m0_ready, m1_ready);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        model_last = 1;
        slv_never = 0; slv_auto = 1;
        @(posedge clk);
        @(negedge clk);
        n = cyc;
        set_master(0, 1'b0, 32'h7000_0100, 32'h0, 4'hF);
        set_master(1, 1'b1, 32'h7000_0200, 32'hDEAD_0002, 4'b1100);
        expect_auto(n, 1'b1, 1'b1);
        monitor(12, 1'b0, 1'b0);
        n_tests++;
        if (evq.size() != 2) begin
            n_fail++; $display("FAIL ar_count: %0d completions expected 2", evq.size());
        end
        for (int k = 0; k < 2 && k < evq.size(); k++) begin
            n_tests++;
            if (evq[k].m != exq[k].m || evq[k].c != exq[k].c || evq[k].rd !== exq[k].rd || evq[k].er !== exq[k].er) begin
                n_fail++; $display("FAIL ar_ev%0d: m%0d cyc %0d rd=%h er=%b expected m%0d cyc %0d rd=%h er=%b",
                                   k, evq[k].m, evq[k].c, evq[k].rd, evq[k].er,
                                   exq[k].m, exq[k].c, exq[k].rd, exq[k].er);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_contention();
        test_timeout();
        test_slverr();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
